// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer: single-sample holding register feeding a 16-bit SPI DAC
// frame once per sample tick (IDLE -> SHIFT -> GAP -> IDLE).
// Optional build macro DAC_UNDERRUN_REPEAT_EN: on underrun, resend the last
// real sample instead of mid-scale silence.
module dac_spi_serializer #(
  parameter int unsigned SAMPLE_DIV = 1042,
  parameter int unsigned SCLK_DIV   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_sample,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  output logic        o_dac_sclk,
  output logic        o_dac_din,
  output logic        o_dac_cs_n,
  output logic        o_busy,
  output logic [7:0]  o_underrun_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned PH_W   = (SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(SCLK_DIV - 1);
  localparam logic [DATA_W-1:0] MID_SCALE = 16'h8000;
  localparam logic [7:0]        UR_MAX    = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

`ifdef DAC_UNDERRUN_REPEAT_EN
  localparam bit REPEAT_LAST = 1'b1;
`else
  localparam bit REPEAT_LAST = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [7:0]        underrun_d;
  logic              sclk_d, din_d, cs_n_d;

  logic              tick_c;
  logic              accept_c;
  logic [DATA_W-1:0] underrun_word_c;
  logic [DATA_W-1:0] load_word_c;

  assign tick_c          = (tick_cnt_q == TICK_LAST);
  assign accept_c        = i_sample_valid && o_sample_ready;
  assign underrun_word_c = REPEAT_LAST ? last_q : MID_SCALE;
  assign load_word_c     = hold_full_q ? hold_data_q : underrun_word_c;

  // Free-running sample-period counter; tick_c marks the wrap cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
    end else if (tick_c) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  // Next-state and next-output logic for the frame FSM and holding register.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    last_d      = last_q;
    underrun_d  = o_underrun_count;
    sclk_d      = o_dac_sclk;
    din_d       = o_dac_din;
    cs_n_d      = o_dac_cs_n;

    if (accept_c) begin
      hold_full_d = 1'b1;
      hold_data_d = i_sample;
    end

    case (state_q)
      ST_IDLE: begin
        // Tick judged on the pre-acceptance holding state.
        if (tick_c) begin
          if (hold_full_q) begin
            hold_full_d = 1'b0;
            last_d      = hold_data_q;
          end else if (o_underrun_count != UR_MAX) begin
            underrun_d = o_underrun_count + 8'd1;
          end
          state_d = ST_SHIFT;
          shreg_d = load_word_c;
          din_d   = load_word_c[DATA_W-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          ph_d    = '0;
          bit_d   = BIT_W'(DATA_W - 1);
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = ST_GAP;
            cs_n_d  = 1'b1;
            din_d   = 1'b0;
          end else begin
            bit_d = bit_q - BIT_W'(1);
            din_d = shreg_q[bit_q - BIT_W'(1)];
          end
        end else begin
          ph_d   = ph_q + PH_W'(1);
          sclk_d = (ph_q >= PH_RISE);
        end
      end
      ST_GAP: begin
        if (ph_q == PH_LAST) begin
          state_d = ST_IDLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ph_d    = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= ST_IDLE;
      ph_q             <= '0;
      bit_q            <= '0;
      shreg_q          <= '0;
      hold_full_q      <= 1'b0;
      hold_data_q      <= '0;
      last_q           <= MID_SCALE;
      o_underrun_count <= '0;
      o_dac_sclk       <= 1'b0;
      o_dac_din        <= 1'b0;
      o_dac_cs_n       <= 1'b1;
      o_sample_ready   <= 1'b1;
      o_busy           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ph_q             <= ph_d;
      bit_q            <= bit_d;
      shreg_q          <= shreg_d;
      hold_full_q      <= hold_full_d;
      hold_data_q      <= hold_data_d;
      last_q           <= last_d;
      o_underrun_count <= underrun_d;
      o_dac_sclk       <= sclk_d;
      o_dac_din        <= din_d;
      o_dac_cs_n       <= cs_n_d;
      o_sample_ready   <= ~hold_full_d;
      o_busy           <= (state_d != ST_IDLE);
    end
  end

  // A frame plus the return to IDLE must fit inside one sample period.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (SAMPLE_DIV >= 34 * SCLK_DIV + 2)
        else $error("dac_spi_serializer: SAMPLE_DIV too small for SCLK_DIV");
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// tb_dac_spi_serializer: directed checks of framing, back-pressure, underrun,
// same-cycle tick/accept, mid-frame reset and counter saturation.
module tb_dac_spi_serializer;

  localparam int unsigned SAMPLE_DIV = 200;
  localparam int unsigned SCLK_DIV   = 4;

`ifdef DAC_UNDERRUN_REPEAT_EN
  localparam logic [15:0] UR_WORD = 16'h7FFF;
`else
  localparam logic [15:0] UR_WORD = 16'h8000;
`endif

  typedef struct {
    logic [15:0] word;
    int          bits;
    int          cs;
    int          busy;
    int          start;
    int          gap_bad;
    int          din_bad;
  } frame_t;

  logic        clk;
  logic        rst;
  logic [15:0] sample;
  logic        valid;
  logic        ready;
  logic        sclk;
  logic        din;
  logic        cs_n;
  logic        busy;
  logic [7:0]  ucnt;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  frame_t q[$];

  dac_spi_serializer #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .SCLK_DIV  (SCLK_DIV)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_sample        (sample),
    .i_sample_valid  (valid),
    .o_sample_ready  (ready),
    .o_dac_sclk      (sclk),
    .o_dac_din       (din),
    .o_dac_cs_n      (cs_n),
    .o_busy          (busy),
    .o_underrun_count(ucnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: 0 in the cycle right after the last reset edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Frame monitor: reconstructs each frame from the pins and queues it.
  logic   m_in_frame = 1'b0;
  logic   m_prev_sclk = 1'b0;
  logic   m_prev_din = 1'b0;
  frame_t m_f;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_in_frame  = 1'b0;
        m_prev_sclk = 1'b0;
      end else begin
        if (!m_in_frame && busy) begin
          m_in_frame = 1'b1;
          m_f.word = '0; m_f.bits = 0; m_f.cs = 0; m_f.busy = 0;
          m_f.start = cyc; m_f.gap_bad = 0; m_f.din_bad = 0;
        end
        if (m_in_frame) begin
          if (busy) m_f.busy++;
          if (!cs_n) m_f.cs++;
          if (busy && cs_n && (sclk || din)) m_f.gap_bad++;
          if (sclk && m_prev_sclk && (din != m_prev_din)) m_f.din_bad++;
          if (sclk && !m_prev_sclk) begin
            m_f.word = {m_f.word[14:0], din};
            m_f.bits++;
          end
          if (!busy) begin
            q.push_back(m_f);
            m_in_frame = 1'b0;
          end
        end
        m_prev_sclk = sclk;
        m_prev_din  = din;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("wait_cyc", cyc, target);
  endtask

  task automatic get_frame(output frame_t f);
    int guard = 0;
    logic got;
    while (q.size() == 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    got = (q.size() != 0);
    check_eq("frame_wait", got, 1);
    if (got) f = q.pop_front();
    else begin
      f.word = 'x; f.bits = -1; f.cs = -1; f.busy = -1;
      f.start = -1; f.gap_bad = -1; f.din_bad = -1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_word, input int exp_start);
    frame_t f;
    get_frame(f);
    check_eq({tag, "_word"},  f.word,    exp_word);
    check_eq({tag, "_bits"},  f.bits,    16);
    check_eq({tag, "_cs"},    f.cs,      32 * SCLK_DIV);
    check_eq({tag, "_busy"},  f.busy,    34 * SCLK_DIV);
    check_eq({tag, "_start"}, f.start,   exp_start);
    check_eq({tag, "_gap"},   f.gap_bad, 0);
    check_eq({tag, "_din"},   f.din_bad, 0);
  endtask

  // Drive one sample for exactly one cycle, starting at the current negedge.
  task automatic push_one(input logic [15:0] s);
    sample = s;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  initial begin
    int ready_cyc;
    int bad;
    rst    = 1'b1;
    valid  = 1'b0;
    sample = '0;
    repeat (3) @(negedge clk);

    check_eq("rst_cs_n",  cs_n,  1);
    check_eq("rst_sclk",  sclk,  0);
    check_eq("rst_din",   din,   0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_busy",  busy,  0);
    check_eq("rst_ucnt",  ucnt,  0);
    rst = 1'b0;

    // Basic frame
    push_one(16'hA5C3);
    check_eq("accept_ready_low", ready, 0);
    check_frame("f1", 16'hA5C3, 200);
    check_eq("f1_ready", ready, 1);
    check_eq("f1_ucnt",  ucnt,  0);

    // Back-pressure: valid held high across two words
    sample = 16'h1234;
    valid  = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_low", ready, 0);
    sample = 16'h5678;
    ready_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("bp_ready_back", ready_cyc, 400);
    @(negedge clk);
    valid = 1'b0;
    check_eq("bp_second_accept", ready, 0);
    check_frame("f2", 16'h1234, 400);
    check_frame("f3", 16'h5678, 600);

    // Underrun after a frame of 7FFF
    push_one(16'h7FFF);
    check_frame("f4", 16'h7FFF, 800);
    check_eq("f4_ucnt", ucnt, 0);
    check_frame("f5_underrun", UR_WORD, 1000);
    check_eq("f5_ucnt", ucnt, 1);

    // Accept in the tick cycle with the holding register empty
    wait_cyc(1199);
    check_eq("tick_acc_ready", ready, 1);
    push_one(16'h3C5A);
    check_eq("tick_acc_held", ready, 0);
    check_frame("f6_underrun", UR_WORD, 1200);
    check_eq("f6_ucnt", ucnt, 2);
    check_frame("f7", 16'h3C5A, 1400);

    // Reset during bit 8 with a word waiting in the holding register
    push_one(16'hFFFF);
    wait_cyc(1620);
    push_one(16'h1111);
    wait_cyc(1600 + 7 * 2 * SCLK_DIV + 2);
    check_eq("pre_rst_cs_n",  cs_n,  0);
    check_eq("pre_rst_din",   din,   1);
    check_eq("pre_rst_ucnt",  ucnt,  2);
    check_eq("pre_rst_ready", ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_cs_n",  cs_n,  1);
    check_eq("mid_rst_sclk",  sclk,  0);
    check_eq("mid_rst_din",   din,   0);
    check_eq("mid_rst_ucnt",  ucnt,  0);
    check_eq("mid_rst_ready", ready, 1);
    check_eq("mid_rst_busy",  busy,  0);
    rst = 1'b0;
    check_frame("post_rst", 16'h8000, 200);
    check_eq("post_rst_ucnt", ucnt, 1);

    // Saturation over 300 empty ticks
    wait_cyc(254 * SAMPLE_DIV + 150);
    check_eq("sat_254", ucnt, 254);
    wait_cyc(300 * SAMPLE_DIV + 150);
    check_eq("sat_255", ucnt, 255);
    check_eq("sat_frames", q.size(), 299);
    bad = 0;
    foreach (q[i]) if (q[i].word !== 16'h8000) bad++;
    check_eq("sat_words", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
